fpu_wb_queue: RTL

Result-side companion to the FPU pipeline. It captures every result the FPU emits (fixed latency, no backpressure) into an in-order completion FIFO and drains it to the shared writeback port with a valid/ready handshake. It tracks operations still in flight so the FPU issue logic never starts an operation that has no guaranteed FIFO slot. It sits between the FPU result outputs and the PRF/FCR writeback arbiter.

---
 rtl/fpu_wb_queue.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fpu_wb_queue.sv
// In-order completion FIFO between the fixed-latency FPU result port and the shared
// writeback arbiter; also tracks in-flight FPU ops so issue only starts with a reserved slot.
module fpu_wb_queue #(
    parameter int LG_PRF_WIDTH = 4,
    parameter int LG_ROB_WIDTH = 4,
    parameter int LG_FCR_WIDTH = 4,
    parameter int LG_DEPTH     = 3,
    parameter int FPU_LATENCY  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fpu_start,
    output logic                    fpu_issue_ok,
    input  logic                    fpu_val,
    input  logic                    fpu_cmp_val,
    input  logic [63:0]             fpu_y,
    input  logic [LG_ROB_WIDTH-1:0] fpu_rob_ptr,
    input  logic [LG_PRF_WIDTH-1:0] fpu_dst_ptr,
    input  logic [LG_FCR_WIDTH-1:0] fpu_fcr_ptr,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic                    wb_is_fcr,
    output logic [63:0]             wb_data,
    output logic [LG_ROB_WIDTH-1:0] wb_rob_ptr,
    output logic [LG_PRF_WIDTH-1:0] wb_dst_ptr,
    output logic [LG_FCR_WIDTH-1:0] wb_fcr_ptr,
    output logic [LG_DEPTH:0]       occupancy,
    output logic                    overflow
);
    localparam int DEPTH = 1 << LG_DEPTH;
    localparam int CNT_W = LG_DEPTH + 1;
    // +2 keeps the width non-zero and wide enough for 0..FPU_LATENCY
    localparam int IF_W  = $clog2(FPU_LATENCY + 2);

    logic                    is_fcr_mem [DEPTH];
    logic [63:0]             data_mem   [DEPTH];
    logic [LG_ROB_WIDTH-1:0] rob_mem    [DEPTH];
    logic [LG_PRF_WIDTH-1:0] dst_mem    [DEPTH];
    logic [LG_FCR_WIDTH-1:0] fcr_mem    [DEPTH];

    logic [LG_DEPTH-1:0] head_reg, head_next;
    logic [LG_DEPTH-1:0] tail_reg, tail_next;
    logic [CNT_W-1:0]    count_reg, count_next;
    logic [IF_W-1:0]     inflight_reg, inflight_next;
    logic                overflow_reg, overflow_next;

    logic enq;
    logic deq;
    logic full;
    logic enq_accept;
    int   infl_calc;

    assign enq  = fpu_val | fpu_cmp_val;
    assign deq  = wb_valid & wb_ready;
    assign full = (count_reg == CNT_W'(DEPTH));
    // A full FIFO still accepts when the head leaves in the same cycle
    assign enq_accept = enq & (~full | deq);

    always_comb begin
        head_next     = deq ? head_reg + LG_DEPTH'(1) : head_reg;
        tail_next     = enq_accept ? tail_reg + LG_DEPTH'(1) : tail_reg;
        count_next    = count_reg;
        if (enq_accept && !deq) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!enq_accept && deq) begin
            count_next = count_reg - CNT_W'(1);
        end
        overflow_next = overflow_reg | (enq & ~enq_accept);
    end

    // Saturating in-flight count: a start beyond the reservation is still tracked, never wraps
    always_comb begin
        infl_calc = int'(inflight_reg) + int'(fpu_start);
        if (enq && infl_calc != 0) begin
            infl_calc = infl_calc - 1;
        end
        if (infl_calc > FPU_LATENCY) begin
            infl_calc = FPU_LATENCY;
        end
        inflight_next = IF_W'(infl_calc);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            inflight_reg <= '0;
            overflow_reg <= 1'b0;
        end else begin
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            count_reg    <= count_next;
            inflight_reg <= inflight_next;
            overflow_reg <= overflow_next;
        end
    end

    // Storage is not reset; validity comes solely from count_reg
    always_ff @(posedge clk) begin
        if (enq_accept) begin
            is_fcr_mem[tail_reg] <= fpu_cmp_val;
            data_mem[tail_reg]   <= fpu_y;
            rob_mem[tail_reg]    <= fpu_rob_ptr;
            dst_mem[tail_reg]    <= fpu_dst_ptr;
            fcr_mem[tail_reg]    <= fpu_fcr_ptr;
        end
    end

    assign wb_valid     = (count_reg != '0);
    assign wb_is_fcr    = wb_valid & is_fcr_mem[head_reg];
    assign wb_data      = wb_valid ? data_mem[head_reg] : '0;
    assign wb_rob_ptr   = wb_valid ? rob_mem[head_reg] : '0;
    assign wb_dst_ptr   = wb_valid ? dst_mem[head_reg] : '0;
    assign wb_fcr_ptr   = wb_valid ? fcr_mem[head_reg] : '0;
    assign occupancy    = count_reg;
    assign overflow     = overflow_reg;
    assign fpu_issue_ok = (32'(count_reg) + 32'(inflight_reg)) < 32'(DEPTH);

endmodule
